// File: rtl/rv_isa_pkg.sv
// RV32I encode-side constants and types shared by the program encoder, its
// field packer and the control decoder.
package rv_isa_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] F3_LWSW = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ALUControl codes as seen by the control decoder
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b010;

  typedef enum logic [1:0] {K_LW = 2'b00, K_SW = 2'b01, K_R = 2'b10, K_BEQ = 2'b11} kind_e;
  typedef enum logic [1:0] {E_NONE = 2'b00, E_ALU = 2'b01, E_IMM = 2'b10, E_OVF = 2'b11} err_e;

  typedef struct packed {
    kind_e       kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } enc_req_t;
endpackage

// File: rtl/rv_field_pack.sv
// Combinational RV32I word assembly and legality check for one request.
module rv_field_pack
  import rv_isa_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output err_e        err
);
  logic [2:0] f3;
  logic [6:0] f7;
  logic       alu_ok;

  always_comb begin
    f3     = F3_ADD;
    f7     = F7_BASE;
    alu_ok = 1'b1;
    case (req.alu)
      ALU_ADD: f3 = F3_ADD;
      ALU_SUB: begin f3 = F3_ADD; f7 = F7_SUB; end
      ALU_SLT: f3 = F3_SLT;
      ALU_OR:  f3 = F3_OR;
      ALU_AND: f3 = F3_AND;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    word = '0;
    err  = E_NONE;
    case (req.kind)
      K_LW: begin
        word = {req.imm[11:0], req.rs1, F3_LWSW, req.rd, OP_LW};
        if (req.imm[12] != req.imm[11]) err = E_IMM;
      end
      K_SW: begin
        word = {req.imm[11:5], req.rs2, req.rs1, F3_LWSW, req.imm[4:0], OP_SW};
        if (req.imm[12] != req.imm[11]) err = E_IMM;
      end
      K_R: begin
        word = {f7, req.rs2, req.rs1, f3, req.rd, OP_R};
        if (!alu_ok) err = E_ALU;
      end
      default: begin
        word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                req.imm[4:1], req.imm[11], OP_BEQ};
        if (req.imm[0]) err = E_IMM;
      end
    endcase
  end
endmodule

// File: rtl/program_encoder.sv
// Streams encoded RV32I words into instruction memory from address 0,
// one accepted request per two cycles, until the last word or a fault.
module program_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_EMIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;
  logic [31:0]       word_q;
  logic              last_q;
  err_e              ecode;

  enc_req_t    req;
  logic [31:0] pk_word;
  err_e        pk_err;

  assign req = '{kind: kind_e'(in_kind), alu: in_alu, rd: in_rd,
                 rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  rv_field_pack u_pack (.req(req), .word(pk_word), .err(pk_err));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_LOAD;
      addr   <= '0;
      cnt    <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      ecode  <= E_NONE;
    end else begin
      case (state)
        S_LOAD: if (in_valid) begin
          if (pk_err != E_NONE) begin
            ecode <= pk_err;
            state <= S_FAULT;
          end else begin
            word_q <= pk_word;
            last_q <= in_last;
            state  <= S_EMIT;
          end
        end
        S_EMIT: begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt + (ADDR_W+1)'(1);
          if (last_q) state <= S_DONE;
          else if (addr == {ADDR_W{1'b1}}) begin
            ecode <= E_OVF;
            state <= S_FAULT;
          end else state <= S_LOAD;
        end
        S_DONE: if (start) begin
          addr  <= '0;
          cnt   <= '0;
          state <= S_LOAD;
        end
        default: if (start) begin
          addr  <= '0;
          cnt   <= '0;
          ecode <= E_NONE;
          state <= S_LOAD;
        end
      endcase
    end
  end

  // write enable is gated by reset combinationally so a reset in EMIT never writes
  assign we       = (state == S_EMIT) & ~reset;
  assign wa       = addr;
  assign wd       = word_q;
  assign count    = cnt;
  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_LOAD);
  assign done     = (state == S_DONE);
  assign err      = (state == S_FAULT);
  assign err_code = ecode;
endmodule

// File: tb/tb_program_encoder.sv
// Directed bench for program_encoder: vector table plus restart, reset-in-EMIT
// and overflow sequences (overflow on a second, 4-deep instance).
module tb_program_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset2, start, in_valid, in_last;
  logic [1:0]  in_kind;
  logic [2:0]  in_alu;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;

  logic        in_ready, we, busy, done, err;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [6:0]  count;
  logic [1:0]  err_code;

  logic        in_ready2, we2, busy2, done2, err2;
  logic [1:0]  wa2;
  logic [31:0] wd2;
  logic [2:0]  count2;
  logic [1:0]  err_code2;

  program_encoder #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .we(we), .wa(wa), .wd(wd), .count(count),
    .busy(busy), .done(done), .err(err), .err_code(err_code));

  program_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .we(we2), .wa(wa2), .wd(wd2), .count(count2),
    .busy(busy2), .done(done2), .err(err2), .err_code(err_code2));

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic [31:0] word;
    logic [1:0]  ecode;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic last);
    in_kind = v.kind; in_alu = v.alu; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_imm = v.imm; in_last = last; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] k, input logic [2:0] a, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                              input logic [31:0] w, input logic [1:0] e);
    vec_t v;
    v.kind = k; v.alu = a; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.word = w; v.ecode = e;
    return v;
  endfunction

  vec_t tbl[16];
  int   exp_wa;

  initial begin
    tbl[0]  = mk(2'b00, 3'b000, 5,  2,  0,  13'd8,    32'h00812283, 2'b00); // lw x5,8(x2)
    tbl[1]  = mk(2'b10, 3'b000, 1,  2,  3,  13'd0,    32'h003100B3, 2'b00); // add
    tbl[2]  = mk(2'b10, 3'b001, 3,  1,  2,  13'd0,    32'h402081B3, 2'b00); // sub
    tbl[3]  = mk(2'b10, 3'b101, 4,  5,  6,  13'd0,    32'h0062A233, 2'b00); // slt
    tbl[4]  = mk(2'b10, 3'b011, 7,  8,  9,  13'd0,    32'h009463B3, 2'b00); // or
    tbl[5]  = mk(2'b10, 3'b010, 10, 11, 12, 13'd0,    32'h00C5F533, 2'b00); // and
    tbl[6]  = mk(2'b01, 3'b000, 0,  2,  6,  13'h1FFC, 32'hFE612E23, 2'b00); // sw x6,-4(x2)
    tbl[7]  = mk(2'b11, 3'b000, 0,  1,  2,  13'h1FF8, 32'hFE208CE3, 2'b00); // beq -8
    tbl[8]  = mk(2'b00, 3'b000, 1,  0,  0,  13'h07FF, 32'h7FF02083, 2'b00); // lw +2047
    tbl[9]  = mk(2'b00, 3'b000, 1,  0,  0,  13'h1800, 32'h80002083, 2'b00); // lw -2048
    tbl[10] = mk(2'b10, 3'b100, 1,  2,  3,  13'd0,    32'h0,        2'b01); // bad alu
    tbl[11] = mk(2'b11, 3'b000, 0,  1,  2,  13'd7,    32'h0,        2'b10); // beq odd
    tbl[12] = mk(2'b00, 3'b000, 1,  0,  0,  13'h0800, 32'h0,        2'b10); // lw +2048
    tbl[13] = mk(2'b01, 3'b000, 0,  1,  2,  13'h1000, 32'h0,        2'b10); // sw -4096
    tbl[14] = mk(2'b10, 3'b111, 1,  2,  3,  13'd0,    32'h0,        2'b01); // bad alu
    tbl[15] = mk(2'b11, 3'b000, 0,  1,  2,  13'd6,    32'h00208363, 2'b00); // beq +6

    reset = 1'b1; reset2 = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_alu = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);

    exp_wa = 0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i], 1'b0);
      if (tbl[i].ecode == 2'b00) begin
        chk($sformatf("v%0d_we", i), 32'(we), 32'd1);
        chk($sformatf("v%0d_wa", i), 32'(wa), 32'(exp_wa));
        chk($sformatf("v%0d_wd", i), wd, tbl[i].word);
        tick();
        exp_wa++;
        chk($sformatf("v%0d_we_off", i), 32'(we), 32'd0);
        chk($sformatf("v%0d_count", i), 32'(count), 32'(exp_wa));
        chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      end else begin
        chk($sformatf("v%0d_we", i), 32'(we), 32'd0);
        chk($sformatf("v%0d_err", i), 32'(err), 32'd1);
        chk($sformatf("v%0d_code", i), 32'(err_code), 32'(tbl[i].ecode));
        chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        exp_wa = 0;
        chk($sformatf("v%0d_clr_err", i), 32'(err), 32'd0);
        chk($sformatf("v%0d_clr_code", i), 32'(err_code), 32'd0);
        chk($sformatf("v%0d_clr_cnt", i), 32'(count), 32'd0);
        chk($sformatf("v%0d_clr_ready", i), 32'(in_ready), 32'd1);
      end
    end

    // two-word program ending in DONE, then restart
    reset = 1'b1; tick(); reset = 1'b0;
    drive(tbl[2], 1'b0);
    chk("prog_wd0", wd, 32'h402081B3);
    chk("prog_wa0", 32'(wa), 32'd0);
    tick();
    drive(tbl[6], 1'b1);
    chk("prog_wd1", wd, 32'hFE612E23);
    chk("prog_wa1", 32'(wa), 32'd1);
    tick();
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_count", 32'(count), 32'd2);
    chk("prog_ready", 32'(in_ready), 32'd0);
    drive(tbl[0], 1'b0);
    chk("done_ignores_valid", 32'(we), 32'd0);
    chk("done_wa_hold", 32'(wa), 32'd2);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_wa", 32'(wa), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
    chk("restart_count", 32'(count), 32'd0);

    // reset lands while the word is being emitted
    drive(tbl[7], 1'b1);
    chk("emit_we", 32'(we), 32'd1);
    reset = 1'b1; #1;
    chk("rst_emit_we", 32'(we), 32'd0);
    tick(); reset = 1'b0;
    chk("rst_emit_busy", 32'(busy), 32'd0);
    chk("rst_emit_ready", 32'(in_ready), 32'd1);
    chk("rst_emit_count", 32'(count), 32'd0);

    // overflow on the 4-word instance
    reset = 1'b1; reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[1], 1'b0);
      chk($sformatf("ovf_we%0d", i), 32'(we2), 32'd1);
      chk($sformatf("ovf_wa%0d", i), 32'(wa2), 32'(i));
      tick();
    end
    chk("ovf_err", 32'(err2), 32'd1);
    chk("ovf_code", 32'(err_code2), 32'd3);
    chk("ovf_count", 32'(count2), 32'd4);
    chk("ovf_we_off", 32'(we2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
